cic_d: RTL
==========

# cic_d

Cascaded integrator-comb decimator: the receive-side counterpart of the team's CIC interpolator. It accepts qualified input samples at the high rate and produces one filtered sample per `r` accepted inputs. The block sits after the ADC/front-end sample stream and feeds low-rate processing with a single-cycle valid strobe.

## Interface
Parameters:
- `dw`, 8: input data width, signed.
- `r`, 4: decimation ratio, ≥2.
- `m`, 4: filter order, the number of integrator stages and also of comb stages.
- `g`, 1: differential delay in combs, 1 or 2.
- Derived `bg` = `$clog2((r*g)**m)`: bit growth.
- Derived `ow` = `dw+bg`: full output width.

Ports:
- `clk`, input, 1: clock; all logic on rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_dv`, input, 1: `data_in` valid this cycle.
- `data_in`, input, `dw`: signed input sample.
- `data_out`, output, `ow` (`dw` with `CIC_D_GAIN_NORM_EN`): signed decimated sample; holds between strobes.
- `out_dv`, output, 1: one-cycle strobe, `data_out` new.

## Operation
- Reset state:
  - All integrator, comb and delay-line registers are 0.
  - Phase counter = 0, `out_dv` = 0, `data_out` = 0.
- Integrator section:
  - `m` registered stages, each `ow` wide; `data_in` is sign-extended to `ow`.
  - Stage k: `acc_k <= acc_k + in_k`, updated only in cycles with `in_dv`=1.
  - The stages form a pipeline, one register per stage.
  - Two's-complement wrap-around is intended; no saturation anywhere.
- Phase counter:
  - Range 0..r-1; increments on `in_dv`.
  - On `in_dv` with count r-1 it wraps to 0 and raises the internal strobe `dec_q` for the next cycle.
  - No `in_dv` means no count change; gaps in `in_dv` are allowed.
- Comb section:
  - `m` stages, each `ow` wide, all enabled by `dec_q`.
  - Stage k holds a `g`-deep delay line of its decimated input: `y <= x - x[n-g]`.
  - Each stage has a registered output, and the delay line shifts only when enabled.
  - Comb input is the last integrator register.
- Output:
  - `data_out` = last comb register, or its normalized form.
  - `out_dv` = `dec_q` delayed one cycle.
- Overall gain is (r*g)^m; the result is exact in `ow` bits.

## Timing
- Strobe chain:
  - Cycle t: `in_dv`=1 with counter r-1.
  - t+1: `dec_q`=1, combs update.
  - t+2: `out_dv`=1 for exactly one cycle, `data_out` valid.
- `out_dv` period is exactly r accepted inputs; minimum spacing is r cycles.
- `in_dv` arriving in the same cycle as `dec_q` or `out_dv` is accepted normally; no input is ever stalled or dropped.
- Reset asserted mid-operation clears everything immediately. After release, the first `out_dv` comes 2 cycles after the r-th accepted input.
- Steady-state DC response is reached from the 8th `out_dv` onward (defaults).

## Configuration
- `CIC_D_GAIN_NORM_EN` defined:
  - Adds an output stage: arithmetic right shift by `bg`, round half up (add `1<<(bg-1)` before the shift).
  - Saturates to the `dw` signed range.
  - `data_out` is `dw` wide.
  - This stage is combinational on the last comb register, so latency is unchanged.
- `CIC_D_GAIN_NORM_EN` not defined: `data_out` is the raw `ow`-bit comb output, unscaled.

## Structure
- Package `cic_d_pkg`:
  - Function `cic_bg(r,m,g)` returning bit growth.
  - Localparam helpers for `ow`.
  - Rounding/saturation function used by the normalization stage.
- Natural sub-module: `cic_d_comb`, a single comb stage with parameters width and `g`, ports `clk`, `reset_n`, `en`, `x`, `y`. It is instantiated `m` times in a generate loop.
- Integrators and the phase counter are inline in `cic_d`.

## Test plan
- DC: `data_in`=1, `in_dv`=1 every cycle (defaults) → `out_dv` every 4 cycles; `data_out`=256 from the 8th strobe onward.
- Extremes: `data_in`=127 → 32512; `data_in`=-128 → -32768; no wrap on output.
- Gapped input: `in_dv` every 3rd cycle, `data_in`=1 → `out_dv` every 12 cycles; values identical to the DC case.
- Impulse: single `data_in`=1 then zeros → sum of all subsequent `data_out` samples = 64; output returns to 0 and stays there.
- Reset mid-stream: drop `reset_n` between strobes → outputs 0 at once. After release, the first `out_dv` comes 2 cycles after the 4th accepted input.
- With `CIC_D_GAIN_NORM_EN`: DC 1 → 1; 127 → 127; -128 → -128; `out_dv` timing unchanged.

Source files
------------

// File: rtl/cic_d_pkg.sv
// Shared helpers for the CIC decimator: bit-growth sizing and output normalization.
// The normalization function is used only when CIC_D_GAIN_NORM_EN is defined.
package cic_d_pkg;

    function automatic int cic_bg(input int rr, input int mm, input int gg);
        longint gain;
        int     bits;
        gain = 64'sd1;
        for (int i = 0; i < mm; i++) begin
            gain = gain * longint'(rr * gg);
        end
        bits = 0;
        while ((64'sd1 <<< bits) < gain) begin
            bits++;
        end
        return bits;
    endfunction

    function automatic int cic_ow(input int dw, input int rr, input int mm, input int gg);
        return dw + cic_bg(rr, mm, gg);
    endfunction

    // Arithmetic shift right by sh with round-half-up, then clamp to a w-bit signed range
    function automatic logic signed [63:0] cic_round_sat(input logic signed [63:0] x,
                                                         input int sh, input int w);
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (sh > 0) begin
            t = (x + (64'sd1 <<< (sh - 1))) >>> sh;
        end else begin
            t = x;
        end
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (t > hi) begin
            return hi;
        end else if (t < lo) begin
            return lo;
        end else begin
            return t;
        end
    endfunction

endpackage

// File: rtl/cic_d_comb.sv
// One decimated comb stage: y <= x - x[n-g], advancing only when en is high.
module cic_d_comb
    import cic_d_pkg::*;
#(
    parameter int width = 16,
    parameter int g     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [width-1:0] x,
    output logic [width-1:0] y
);

    logic [g-1:0][width-1:0] dly_r;

    // Difference against the sample g decimated steps back; delay line shifts with en
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y     <= '0;
            dly_r <= '0;
        end else if (en) begin
            y        <= x - dly_r[g-1];
            dly_r[0] <= x;
            for (int i = 1; i < g; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_d.sv
// CIC decimator: m integrators at the input rate, m combs at 1/r of accepted inputs.
// Optional macro CIC_D_GAIN_NORM_EN rounds/saturates data_out back to dw bits.
module cic_d
    import cic_d_pkg::*;
#(
    parameter  int dw = 8,
    parameter  int r  = 4,
    parameter  int m  = 4,
    parameter  int g  = 1,
    localparam int bg = cic_bg(r, m, g),
    localparam int ow = cic_ow(dw, r, m, g),
`ifdef CIC_D_GAIN_NORM_EN
    localparam int outw = dw
`else
    localparam int outw = ow
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_dv,
    input  logic [dw-1:0]   data_in,
    output logic [outw-1:0] data_out,
    output logic            out_dv
);

    localparam int cw = $clog2(r);

    logic [m-1:0][ow-1:0] integ_r;
    logic [ow-1:0]        din_ext_s;
    logic [cw-1:0]        phase_r;
    logic                 dec_q_r;
    logic                 out_dv_r;
    logic [m:0][ow-1:0]   comb_s;

    assign din_ext_s = {{bg{data_in[dw-1]}}, data_in};

    // Integrator pipeline, one register per stage, advancing only on accepted samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            integ_r <= '0;
        end else if (in_dv) begin
            integ_r[0] <= integ_r[0] + din_ext_s;
            for (int k = 1; k < m; k++) begin
                integ_r[k] <= integ_r[k] + integ_r[k-1];
            end
        end
    end

    // Phase counter; dec_q_r pulses the cycle after every r-th accepted sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= '0;
            dec_q_r <= 1'b0;
        end else if (in_dv) begin
            if (phase_r == cw'(r - 1)) begin
                phase_r <= '0;
                dec_q_r <= 1'b1;
            end else begin
                phase_r <= phase_r + cw'(1);
                dec_q_r <= 1'b0;
            end
        end else begin
            dec_q_r <= 1'b0;
        end
    end

    assign comb_s[0] = integ_r[m-1];

    for (genvar k = 0; k < m; k++) begin : g_comb
        cic_d_comb #(.width(ow), .g(g)) u_comb (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (dec_q_r),
            .x      (comb_s[k]),
            .y      (comb_s[k+1])
        );
    end

    // Output strobe trails the comb update by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_dv_r <= 1'b0;
        end else begin
            out_dv_r <= dec_q_r;
        end
    end

    assign out_dv = out_dv_r;

`ifdef CIC_D_GAIN_NORM_EN
    logic signed [63:0] norm_s;

    // Remove the (r*g)^m gain straight off the last comb register
    always_comb begin
        norm_s = cic_round_sat(64'($signed(comb_s[m])), bg, dw);
    end

    assign data_out = norm_s[dw-1:0];
`else
    assign data_out = comb_s[m];
`endif

endmodule
